// File: rtl/bcd_alu_serial.sv
// Digit-serial BCD add / subtract unit. Operands are latched on start and
// walked LSB digit first, one digit per clock. A second pass recomputes B-A
// when a signed subtract finds A<B, so the result is always a magnitude.
module bcd_alu_serial #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  sat,
  output logic                  neg,
  output logic                  err
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [2:0] {StIdle, StPass1, StResolve, StPass2, StFinish} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic             cb_q, cb_d;          // carry (add) or borrow (subtract)
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             sat_q, sat_d, neg_q, neg_d, err_q, err_d;
  logic             busy_q, done_q;

  logic [3:0]       dig_a, dig_b, dig_x, dig_y;
  logic [4:0]       sum_t, dif_t;
  logic             last_digit;

  // Single-digit BCD adder and subtractor on the current digit index.
  always_comb begin
    dig_a = a_q[4*int'(idx_q) +: 4];
    dig_b = b_q[4*int'(idx_q) +: 4];
    // The second pass swaps operands to form B-A.
    dig_x = (state_q == StPass2) ? dig_b : dig_a;
    dig_y = (state_q == StPass2) ? dig_a : dig_b;
    sum_t = {1'b0, dig_x} + {1'b0, dig_y} + {4'b0, cb_q};
    if (sum_t > 5'd9) sum_t = sum_t + 5'd6;
    dif_t = {1'b0, dig_x} - {1'b0, dig_y} - {4'b0, cb_q};
    if (dif_t[4]) dif_t = dif_t + 5'd10;
    last_digit = (idx_q == CNT_W'(DIGITS - 1));
  end

  // Next-state and datapath updates for the sequencing FSM.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cb_d     = cb_q;
    idx_d    = idx_q;
    result_d = result_q;
    sat_d    = sat_q;
    neg_d    = neg_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a_bcd;
          b_d     = b_bcd;
          op_d    = op;
          cb_d    = 1'b0;
          idx_d   = '0;
          sat_d   = 1'b0;
          neg_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StPass1;
        end
      end
      StPass1: begin
        if (dig_a > 4'd9 || dig_b > 4'd9) err_d = 1'b1;
        if (op_q[1]) begin
          acc_d[4*int'(idx_q) +: 4] = dif_t[3:0];
          cb_d = (({1'b0, dig_a}) < ({1'b0, dig_b} + {4'b0, cb_q}));
        end else begin
          acc_d[4*int'(idx_q) +: 4] = sum_t[3:0];
          cb_d = sum_t[4];
        end
        idx_d = idx_q + CNT_W'(1);
        if (last_digit) state_d = StResolve;
      end
      StResolve: begin
        idx_d   = '0;
        cb_d    = 1'b0;
        state_d = StFinish;
        if (err_q) begin
          result_d = '0;
          sat_d    = 1'b0;
          neg_d    = 1'b0;
        end else if (!op_q[1]) begin
          result_d = cb_q ? {DIGITS{4'h9}} : acc_q;
          sat_d    = cb_q;
        end else if (!op_q[0]) begin
          result_d = cb_q ? '0 : acc_q;
          sat_d    = cb_q;
        end else if (cb_q) begin
          // A<B: keep the sign, then recompute the magnitude as B-A.
          neg_d   = 1'b1;
          state_d = StPass2;
        end else begin
          result_d = acc_q;
        end
      end
      StPass2: begin
        result_d[4*int'(idx_q) +: 4] = dif_t[3:0];
        cb_d  = (({1'b0, dig_b}) < ({1'b0, dig_a} + {4'b0, cb_q}));
        idx_d = idx_q + CNT_W'(1);
        if (last_digit) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; busy/done are registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      cb_q     <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      cb_q     <= cb_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      sat_q    <= sat_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      busy_q   <= (state_d != StIdle);
      done_q   <= (state_q == StFinish);
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign sat    = sat_q;
  assign neg    = neg_q;
  assign err    = err_q;

endmodule
